// File: rtl/lsu_tlb_rdret_q_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_tlb_rdret_q_if
//  Description : Push, return and error-log signals of the DTLB diagnostic
//                read return queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_tlb_rdret_q_if #(
    parameter int DW = 64
);
    logic          tlb_rd_vld_g;
    logic          tlb_rd_is_data_g;
    logic [1:0]    tlb_rd_tid_g;
    logic [DW-1:0] lsu_tlb_rd_data;
    logic          tte_data_parity_error;
    logic          tte_tag_parity_error;
    logic          rdret_ack;
    logic          perr_log_clr;
    logic          rdret_vld;
    logic [DW-1:0] rdret_data;
    logic [1:0]    rdret_tid;
    logic          rdret_perr;
    logic          rdret_afull;
    logic          rdret_ovf;
    logic          perr_log_vld;
    logic [1:0]    perr_log_tid;
    logic          perr_log_type;

    modport master (
        output tlb_rd_vld_g, tlb_rd_is_data_g, tlb_rd_tid_g, lsu_tlb_rd_data,
               tte_data_parity_error, tte_tag_parity_error, rdret_ack, perr_log_clr,
        input  rdret_vld, rdret_data, rdret_tid, rdret_perr, rdret_afull, rdret_ovf,
               perr_log_vld, perr_log_tid, perr_log_type
    );

    modport slave (
        input  tlb_rd_vld_g, tlb_rd_is_data_g, tlb_rd_tid_g, lsu_tlb_rd_data,
               tte_data_parity_error, tte_tag_parity_error, rdret_ack, perr_log_clr,
        output rdret_vld, rdret_data, rdret_tid, rdret_perr, rdret_afull, rdret_ovf,
               perr_log_vld, perr_log_tid, perr_log_type
    );
endinterface
`default_nettype wire

// File: rtl/lsu_tlb_rdret_q.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_tlb_rdret_q
//  Description : Return queue for LSU DTLB diagnostic reads with overflow flag
//                and first-error parity log (LSU_TLB_RDRET_PERR_LOG_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_tlb_rdret_q #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  wire logic         rclk,
    input  wire logic         arst_l,
    lsu_tlb_rdret_q_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef LSU_TLB_RDRET_PERR_LOG_EN
    localparam int EW = DW + 3;
`else
    localparam int EW = DW + 2;
`endif
    localparam logic [AW:0] c_full  = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_afull = (AW+1)'(DEPTH - 1);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_full = (r_count == c_full);
    assign w_pop  = bus.rdret_ack & (r_count != '0);
    // When full, a push is only accepted if the head leaves in the same cycle.
    assign w_push = bus.tlb_rd_vld_g & (~w_full | w_pop);
    assign w_drop = bus.tlb_rd_vld_g & w_full & ~w_pop;

`ifdef LSU_TLB_RDRET_PERR_LOG_EN
    logic       w_perr;
    logic       r_log_vld;
    logic [1:0] r_log_tid;
    logic       r_log_type;

    assign w_perr  = bus.tlb_rd_is_data_g ? bus.tte_data_parity_error
                                          : bus.tte_tag_parity_error;
    assign w_entry = {bus.lsu_tlb_rd_data, bus.tlb_rd_tid_g, w_perr};

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_log_vld  <= 1'b0;
            r_log_tid  <= 2'b00;
            r_log_type <= 1'b0;
        end else if (w_push && w_perr && (!r_log_vld || bus.perr_log_clr)) begin
            r_log_vld  <= 1'b1;
            r_log_tid  <= bus.tlb_rd_tid_g;
            r_log_type <= bus.tlb_rd_is_data_g;
        end else if (bus.perr_log_clr) begin
            r_log_vld  <= 1'b0;
        end
    end

    assign bus.rdret_perr    = w_head[0];
    assign bus.perr_log_vld  = r_log_vld;
    assign bus.perr_log_tid  = r_log_tid;
    assign bus.perr_log_type = r_log_type;
`else
    logic w_unused;

    assign w_unused = bus.tlb_rd_is_data_g ^ bus.tte_data_parity_error
                    ^ bus.tte_tag_parity_error;
    assign w_entry  = {bus.lsu_tlb_rd_data, bus.tlb_rd_tid_g};

    assign bus.rdret_perr    = 1'b0;
    assign bus.perr_log_vld  = 1'b0;
    assign bus.perr_log_tid  = 2'b00;
    assign bus.perr_log_type = 1'b0;
`endif

    // Entries are reset so the head reads all zeros out of reset.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set so it is not lost.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.perr_log_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.rdret_vld   = (r_count != '0);
    assign bus.rdret_data  = w_head[EW-1 -: DW];
    assign bus.rdret_tid   = w_head[EW-DW-1 -: 2];
    assign bus.rdret_afull = (r_count >= c_afull);
    assign bus.rdret_ovf   = r_ovf;
endmodule
`default_nettype wire

// File: doc/lsu_tlb_rdret_q.md
# lsu_tlb_rdret_q

Return queue for LSU DTLB diagnostic reads (ASI tag-read / data-access). Sits directly downstream of the TLB read-formatting datapath: captures each 64-bit formatted tag or data word in G stage, along with its thread and parity status, and buffers it until the ASI load-return path accepts it. It also keeps a first-error log for TTE parity errors. It throttles diagnostic read issue with an almost-full indication.

## Interface
Parameters:
- DEPTH, 4, number of queue entries (power of 2, ≥2)
- DW, 64, return data width

Ports:
- rclk  in  1  core clock
- arst_l  in  1  asynchronous active-low reset
- tlb_rd_vld_g  in  1  formatted TLB read word valid this cycle (G stage)
- tlb_rd_is_data_g  in  1  1 = data-access read, 0 = tag read
- tlb_rd_tid_g  in  2  requesting thread
- lsu_tlb_rd_data  in  DW  formatted tag/data word
- tte_data_parity_error  in  1  data parity mismatch, same cycle as the word
- tte_tag_parity_error  in  1  tag parity mismatch, same cycle as the word
- rdret_ack  in  1  consumer accepts the head entry
- perr_log_clr  in  1  clear the error log and the overflow flag
- rdret_vld  out  1  head entry valid
- rdret_data  out  DW  head data
- rdret_tid  out  2  head thread
- rdret_perr  out  1  head entry carries a parity error
- rdret_afull  out  1  occupancy ≥ DEPTH-1; upstream must not issue new diag reads
- rdret_ovf  out  1  sticky: a push was dropped
- perr_log_vld  out  1  error log holds an entry
- perr_log_tid  out  2  thread of the logged error
- perr_log_type  out  1  1 = data, 0 = tag

## Operation
- Push on tlb_rd_vld_g. Each entry stores {lsu_tlb_rd_data, tlb_rd_tid_g, perr}.
- perr = tlb_rd_is_data_g ? tte_data_parity_error : tte_tag_parity_error. The parity input that does not apply is ignored.
- Pop on rdret_ack & rdret_vld. An ack while the queue is empty is ignored.
- Storage is a circular buffer with wr_ptr, rd_ptr and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Full (count == DEPTH):
  - A push with no pop in the same cycle is dropped: storage, pointers and count are unchanged, and rdret_ovf sets.
  - A push with a simultaneous pop is accepted and count stays at DEPTH.
- Simultaneous push and pop at any other occupancy: both take effect, count unchanged.
- Output is the registered head entry. There is no empty-queue bypass.
- Error log:
  - A push with perr=1 loads {tid, type} and sets perr_log_vld, but only if the log is empty or perr_log_clr is asserted in the same cycle.
  - Later errors are ignored while the log is held.
  - perr_log_clr with no new error clears perr_log_vld and rdret_ovf.
  - A dropped push (full) does not update the log.
- Reset values: count=0, pointers=0, rdret_vld=0, rdret_afull=0, rdret_ovf=0, perr_log_vld=0, perr_log_tid=0, perr_log_type=0. rdret_data/tid/perr read the reset state of entry 0, which is all zeros.

## Timing
- Push-to-visible latency is 1 cycle: a word pushed in cycle N gives rdret_vld=1 in cycle N+1.
- Pop takes effect at the clock edge. The next entry is presented in the following cycle.
- rdret_afull is combinational from registered count, so it is valid the cycle after the push or pop that changes count. Because the threshold is DEPTH-1, one read already in flight can still land.
- Error log updates one cycle after the push.
- Reset is asynchronous: asserting arst_l mid-operation clears all state immediately. No entries survive.

## Configuration
- LSU_TLB_RDRET_PERR_LOG_EN defined:
  - Parity selection, per-entry perr bit and error log are present as described above.
- LSU_TLB_RDRET_PERR_LOG_EN undefined:
  - The perr storage bit and log registers are removed.
  - rdret_perr, perr_log_vld, perr_log_tid and perr_log_type are tied to 0.
  - Parity inputs are unused.
  - perr_log_clr still clears rdret_ovf.

## Test plan
- Reset, then one push of data=64'hDEAD_BEEF_0123_4567, tid=2 -> rdret_vld=1 next cycle with that data and tid=2. Ack -> rdret_vld=0 the cycle after.
- 4 pushes with no ack (DEPTH=4) -> rdret_afull=1 after the 3rd. A 5th push -> dropped, rdret_ovf=1. Drain returns the 4 words in order.
- Queue full, push and ack in the same cycle -> count stays 4, rdret_ovf stays 0, new word appears after 3 more pops.
- Tag push (is_data=0) with tte_data_parity_error=1, tte_tag_parity_error=0 -> rdret_perr=0, log empty. Data push (is_data=1), tid=1, data_err=1 -> rdret_perr=1, perr_log_vld=1, tid=1, type=1. A second error from tid=3 -> log unchanged.
- perr_log_clr in the same cycle as a tag error from tid=3 -> log reloads tid=3, type=0, and rdret_ovf clears.
- arst_l pulsed low for half a cycle while 3 entries are queued -> all outputs are 0 immediately. After release, a push is accepted normally into entry 0.
